// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable LSU data memory:
// size encodings, FSM states, strobe generation and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {CLEAR, READY} state_e;

  // Response-side context captured at accept time.
  typedef struct packed {
    logic       ld;
    logic [1:0] size;
    logic [1:0] lane;
    logic       uns;
  } resp_meta_t;

  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_fault = 1'b0;
      SZ_HALF: is_fault = lane[0];
      SZ_WORD: is_fault = |lane;
      default: is_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: gen_strobe = 4'b0001 << lane;
      SZ_HALF: gen_strobe = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: gen_strobe = 4'b1111;
      default: gen_strobe = 4'b0000;
    endcase
  endfunction

  // Store data is replicated across lanes so the strobe alone picks the target bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_extract = {{16{~uns & h[15]}}, h};
      SZ_WORD: load_extract = word;
      default: load_extract = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response handshake between the core load/store path and the data memory.
interface data_memory_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        init_done;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, init_done
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// DEPTH_WORDS x 32 storage with per-byte write strobes and a synchronous
// read-first port; no reset, contents only change through writes.
module dmem_byte_ram #(
  parameter  int DEPTH_WORDS = 4096,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Read and write share one block so a same-edge access returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[addr][b] <= wdata[b*8 +: 8];
  end
endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory for the RV32I load/store path: strobed stores,
// extended loads, misalignment faults and a post-reset array clear.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 4096,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_lsu_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] clr_cnt;
  logic             clr_active;
  logic             accept, fault, st_en, ld_en;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata, ram_rdata;
  resp_meta_t       meta;
  logic             unused_addr_hi;

  assign lane           = bus.req_addr[1:0];
  assign idx            = bus.req_addr[IDX_W+1:2];
  assign unused_addr_hi = ^bus.req_addr[31:IDX_W+2];
  assign fault          = is_fault(bus.req_size, lane);
  assign accept         = bus.req_valid & bus.req_ready;
  assign st_en          = accept &  bus.req_write & ~fault;
  assign ld_en          = accept & ~bus.req_write & ~fault;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == IDX_W'(DEPTH_WORDS - 1)) state_nxt = READY;
  end

  // Outputs
  always_comb begin
    clr_active    = (state == CLEAR);
    bus.req_ready = (state == READY);
    bus.init_done = (state == READY);
  end

  // The clear sequencer owns the RAM port while it runs.
  always_comb begin
    ram_addr  = clr_active ? clr_cnt : idx;
    ram_we    = clr_active ? 4'b1111 : (st_en ? gen_strobe(bus.req_size, lane) : 4'b0000);
    ram_wdata = clr_active ? 32'h0   : store_data(bus.req_size, bus.req_wdata);
  end

  dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .rd_en (ld_en),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // meta and ram_rdata only move on accept, so rdata/fault hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      meta           <= '0;
    end else begin
      bus.resp_valid <= accept;
      if (accept) begin
        bus.resp_fault <= fault;
        meta           <= '{ld: ~bus.req_write & ~fault, size: bus.req_size,
                            lane: lane, uns: bus.req_unsigned};
      end
    end
  end

  assign bus.resp_rdata = meta.ld ? load_extract(ram_rdata, meta.size, meta.lane, meta.uns) : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu with a 16-word array: clear timing,
// load/store widths, extension, faults, back-to-back traffic and aliasing.
module tb_data_memory_lsu;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  data_memory_lsu_if bus();

  data_memory_lsu #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        output logic v, output logic [31:0] rd, output logic f);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_wdata    = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    v  = bus.resp_valid;
    rd = bus.resp_rdata;
    f  = bus.resp_fault;
  endtask

  task automatic acc(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_f);
    logic v, f;
    logic [31:0] rd;
    do_req(w, a, sz, u, wd, v, rd, f);
    chk({tag, ".valid"}, 32'(v), 32'd1);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".fault"}, 32'(f), 32'(exp_f));
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (!bus.req_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".cycles"}, 32'(cnt), 32'd16);
    chk({tag, ".init_done"}, 32'(bus.init_done), 32'd1);
  endtask

  initial begin
    logic v, f;
    logic [31:0] rd;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready",  32'(bus.req_ready),  32'd0);
    chk("rst.init_done",  32'(bus.init_done),  32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst.resp_fault", 32'(bus.resp_fault), 32'd0);
    reset = 1'b0;
    wait_clear("clear0");

    acc("lw3c", 0, 32'h3C, 2'b10, 0, 0, 32'h0, 0);

    // Width and extension on 0x8899AABB
    acc("sw10",  1, 32'h10, 2'b10, 0, 32'h8899AABB, 32'h0, 0);
    acc("lb13",  0, 32'h13, 2'b00, 0, 0, 32'hFFFFFF88, 0);
    acc("lbu13", 0, 32'h13, 2'b00, 1, 0, 32'h00000088, 0);
    acc("lh12",  0, 32'h12, 2'b01, 0, 0, 32'hFFFF8899, 0);
    acc("lhu10", 0, 32'h10, 2'b01, 1, 0, 32'h0000AABB, 0);
    acc("lw10u", 0, 32'h10, 2'b10, 1, 0, 32'h8899AABB, 0);

    // Partial stores preserve unstrobed bytes
    acc("sw20",  1, 32'h20, 2'b10, 0, 32'h11223344, 32'h0, 0);
    acc("sb21",  1, 32'h21, 2'b00, 0, 32'h000000EE, 32'h0, 0);
    acc("lw20a", 0, 32'h20, 2'b10, 0, 0, 32'h1122EE44, 0);
    acc("sh22",  1, 32'h22, 2'b01, 0, 32'h00005566, 32'h0, 0);
    acc("lw20b", 0, 32'h20, 2'b10, 0, 0, 32'h5566EE44, 0);

    // Faults write nothing and return zero data
    acc("sw04",   1, 32'h04, 2'b10, 0, 32'h11111111, 32'h0, 0);
    acc("f.lw02", 0, 32'h02, 2'b10, 0, 0, 32'h0, 1);
    acc("f.lh01", 0, 32'h01, 2'b01, 0, 0, 32'h0, 1);
    acc("f.sw05", 1, 32'h05, 2'b10, 0, 32'hDEADBEEF, 32'h0, 1);
    acc("f.sz3",  0, 32'h04, 2'b11, 0, 0, 32'h0, 1);
    acc("lw04",   0, 32'h04, 2'b10, 0, 0, 32'h11111111, 0);

    // Back-to-back store then load, then idle hold
    do_req(1, 32'h08, 2'b10, 0, 32'hCAFEF00D, v, rd, f);
    chk("b2b.st.valid", 32'(v), 32'd1);
    do_req(0, 32'h08, 2'b10, 0, 0, v, rd, f);
    chk("b2b.ld.valid", 32'(v), 32'd1);
    chk("b2b.ld.rdata", rd, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("idle.valid", 32'(bus.resp_valid), 32'd0);
    chk("idle.hold",  bus.resp_rdata, 32'hCAFEF00D);

    // Aliasing: bits above the index are ignored
    acc("sw00",  1, 32'h00, 2'b10, 0, 32'h12345678, 32'h0, 0);
    acc("lw40",  0, 32'h40, 2'b10, 0, 0, 32'h12345678, 0);

    // Reset mid-clear restarts from word 0 and clears the whole array
    acc("sw30", 1, 32'h30, 2'b10, 0, 32'h5A5A5A5A, 32'h0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid.ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_clear("clear1");
    acc("lw30z", 0, 32'h30, 2'b10, 0, 0, 32'h0, 0);
    acc("lw00z", 0, 32'h00, 2'b10, 0, 0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
